// File: rtl/row_ptr_times_gen.sv
// CSR row-pointer to per-row non-zero count converter feeding the dot-product TIMES input.
// One registered output stage; reports rows emitted, matrix completion and non-monotonic pointers.
module row_ptr_times_gen #(
  parameter int PTR_W = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PTR_W-1:0] S_AXIS_PTR_tdata,
  input  logic             S_AXIS_PTR_tvalid,
  output logic             S_AXIS_PTR_tready,
  input  logic             S_AXIS_PTR_tlast,
  output logic [PTR_W-1:0] M_AXIS_TIMES_tdata,
  output logic             M_AXIS_TIMES_tvalid,
  input  logic             M_AXIS_TIMES_tready,
  output logic [CNT_W-1:0] rows_emitted,
  output logic             done,
  output logic             err_nonmono
);

  localparam logic [1:0] ST_FIRST = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]       state_r;
  logic [PTR_W-1:0] prev_r;
  logic [PTR_W-1:0] times_data_r;
  logic             times_valid_r;
  logic             done_r;
  logic             err_r;
  logic [CNT_W-1:0] rows_r;

  logic             ptr_ready_s;
  logic             ptr_accept_s;
  logic             times_xfer_s;

  // A pointer that steps backwards yields an empty row rather than a wrapped huge count.
  function automatic logic [PTR_W-1:0] row_times(input logic [PTR_W-1:0] cur,
                                                 input logic [PTR_W-1:0] base);
    if (cur < base) begin
      row_times = {PTR_W{1'b0}};
    end else begin
      row_times = cur - base;
    end
  endfunction

  // Input handshake: ready depends on FSM state and output-register occupancy.
  always_comb begin
    ptr_ready_s = 1'b0;
    if (rst) begin
      ptr_ready_s = 1'b0;
    end else begin
      case (state_r)
        ST_FIRST: ptr_ready_s = 1'b1;
        ST_RUN:   ptr_ready_s = ~times_valid_r | M_AXIS_TIMES_tready;
        ST_FLUSH: ptr_ready_s = 1'b0;
        default:  ptr_ready_s = 1'b0;
      endcase
    end
  end

  assign ptr_accept_s = S_AXIS_PTR_tvalid & ptr_ready_s;
  assign times_xfer_s = times_valid_r & M_AXIS_TIMES_tready;

  // FSM, output register, row counter and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_FIRST;
      prev_r        <= {PTR_W{1'b0}};
      times_data_r  <= {PTR_W{1'b0}};
      times_valid_r <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      rows_r        <= {CNT_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      if (times_xfer_s) begin
        rows_r <= rows_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      case (state_r)
        ST_FIRST: begin
          if (ptr_accept_s) begin
            prev_r <= S_AXIS_PTR_tdata;
            rows_r <= {CNT_W{1'b0}};
            if (S_AXIS_PTR_tlast) begin
              done_r <= 1'b1;
            end else begin
              state_r <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (ptr_accept_s) begin
            times_data_r  <= row_times(S_AXIS_PTR_tdata, prev_r);
            times_valid_r <= 1'b1;
            prev_r        <= S_AXIS_PTR_tdata;
            if (S_AXIS_PTR_tdata < prev_r) begin
              err_r <= 1'b1;
            end
            if (S_AXIS_PTR_tlast) begin
              state_r <= ST_FLUSH;
            end
          end else if (times_xfer_s) begin
            times_valid_r <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (times_xfer_s) begin
            times_valid_r <= 1'b0;
            done_r        <= 1'b1;
            state_r       <= ST_FIRST;
          end
        end
        default: begin
          times_valid_r <= 1'b0;
          state_r       <= ST_FIRST;
        end
      endcase
    end
  end

  assign S_AXIS_PTR_tready   = ptr_ready_s;
  assign M_AXIS_TIMES_tdata  = times_data_r;
  assign M_AXIS_TIMES_tvalid = times_valid_r;
  assign rows_emitted        = rows_r;
  assign done                = done_r;
  assign err_nonmono         = err_r;

endmodule

// File: tb/tb_row_ptr_times_gen.sv
// Scoreboard bench for row_ptr_times_gen: a per-matrix model queues expected beats and
// completion records; a negedge monitor compares every TIMES transfer and handshake.
module tb_row_ptr_times_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] rows_emitted;
  logic        done;
  logic        err_nonmono;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_beats[$];
  int          exp_rows[$];
  logic        exp_errq[$];
  logic        mdl_err;
  logic [31:0] pv[0:15];
  int          rdy_mode;
  int          rdy_cnt;

  logic        mdl_first, mdl_flush, done_exp, lat_pend, hold_v;
  logic [31:0] hold_d, mon_e;
  logic        mon_xfer, mon_acc, done_next, exp_ready;
  int          mon_r;
  logic        mon_er;

  row_ptr_times_gen #(.PTR_W(32), .CNT_W(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .S_AXIS_PTR_tdata    (s_tdata),
    .S_AXIS_PTR_tvalid   (s_tvalid),
    .S_AXIS_PTR_tready   (s_tready),
    .S_AXIS_PTR_tlast    (s_tlast),
    .M_AXIS_TIMES_tdata  (m_tdata),
    .M_AXIS_TIMES_tvalid (m_tvalid),
    .M_AXIS_TIMES_tready (m_tready),
    .rows_emitted        (rows_emitted),
    .done                (done),
    .err_nonmono         (err_nonmono)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready pattern: 0 always, 1 toggled 1,0,0, 2 random, 3 stalled.
  initial begin
    m_tready = 1'b1;
    rdy_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      rdy_cnt++;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = (rdy_cnt % 3 == 0);
        2:       m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Monitor: handshake rules, done timing, scoreboard pops.
  initial begin
    mdl_first = 1'b1; mdl_flush = 1'b0; done_exp = 1'b0; lat_pend = 1'b0;
    hold_v = 1'b0; hold_d = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("ptr_tready_in_reset", s_tready, 1'b0);
        mdl_first = 1'b1; mdl_flush = 1'b0; done_exp = 1'b0; lat_pend = 1'b0; hold_v = 1'b0;
      end else begin
        exp_ready = !mdl_flush && (mdl_first || !m_tvalid || m_tready);
        check("ptr_tready", s_tready, exp_ready);
        check("done", done, done_exp);
        if (done) begin
          if (exp_rows.size() == 0) begin
            check("unexpected_done", 1'b1, 1'b0);
          end else begin
            mon_r  = exp_rows.pop_front();
            mon_er = exp_errq.pop_front();
            check("rows_emitted", rows_emitted, mon_r);
            check("err_nonmono", err_nonmono, mon_er);
          end
        end
        if (lat_pend) check("latency_valid", m_tvalid, 1'b1);
        if (hold_v) begin
          check("hold_valid", m_tvalid, 1'b1);
          check("hold_data", m_tdata, hold_d);
        end
        mon_xfer = m_tvalid & m_tready;
        mon_acc  = s_tvalid & s_tready;
        hold_v   = m_tvalid & ~m_tready;
        hold_d   = m_tdata;
        if (mon_xfer) begin
          if (exp_beats.size() == 0) begin
            check("extra_beat", m_tdata, 32'hDEAD_BEEF);
          end else begin
            mon_e = exp_beats.pop_front();
            check("times_data", m_tdata, mon_e);
          end
        end
        done_next = 1'b0;
        lat_pend  = 1'b0;
        if (mon_xfer && mdl_flush) begin
          mdl_flush = 1'b0;
          mdl_first = 1'b1;
          done_next = 1'b1;
        end
        if (mon_acc) begin
          if (mdl_first) begin
            if (s_tlast) done_next = 1'b1;
            else mdl_first = 1'b0;
          end else begin
            lat_pend = 1'b1;
            if (s_tlast) mdl_flush = 1'b1;
          end
        end
        done_exp = done_next;
      end
    end
  end

  task automatic drive_ptr(input logic [31:0] d, input logic last);
    logic acc;
    int   cnt;
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    acc = 1'b0;
    cnt = 0;
    while (!acc && cnt < 300) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      cnt++;
    end
    if (!acc) check("ptr_accept_timeout", 1'b0, 1'b1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (rdy_mode == 2 && $urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected results come from the pointer list alone: count = next - current, 0 if it steps back.
  task automatic run_matrix(input int n);
    for (int i = 0; i < n; i++) begin
      if (pv[i+1] < pv[i]) begin
        exp_beats.push_back(32'd0);
        mdl_err = 1'b1;
      end else begin
        exp_beats.push_back(pv[i+1] - pv[i]);
      end
    end
    exp_rows.push_back(n);
    exp_errq.push_back(mdl_err);
    for (int i = 0; i <= n; i++) drive_ptr(pv[i], i == n);
  endtask

  task automatic drain();
    int cnt = 0;
    while ((exp_beats.size() != 0 || exp_rows.size() != 0) && cnt < 500) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("drain_beats_left", exp_beats.size(), 0);
    check("drain_dones_left", exp_rows.size(), 0);
  endtask

  initial begin
    rst = 1'b1; s_tdata = 32'd0; s_tvalid = 1'b0; s_tlast = 1'b0;
    rdy_mode = 0; mdl_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ptr_tready", s_tready, 1'b0);
    rst = 1'b0;
    check("reset_tvalid", m_tvalid, 1'b0);
    check("reset_tdata", m_tdata, 32'd0);
    check("reset_rows", rows_emitted, 32'd0);
    check("reset_done", done, 1'b0);
    check("reset_err", err_nonmono, 1'b0);

    pv[0] = 32'd0; pv[1] = 32'd3; pv[2] = 32'd3; pv[3] = 32'd7; pv[4] = 32'd12;
    run_matrix(4);
    drain();

    rdy_mode = 1;
    run_matrix(4);
    drain();
    rdy_mode = 0;

    pv[0] = 32'd5;
    run_matrix(0);
    drain();

    pv[0] = 32'd10; pv[1] = 32'd8; pv[2] = 32'd15;
    run_matrix(2);
    pv[0] = 32'd0; pv[1] = 32'd2;
    run_matrix(1);
    drain();

    pv[0] = 32'hFFFF_FFF0; pv[1] = 32'hFFFF_FFFF;
    run_matrix(1);
    pv[0] = 32'd0; pv[1] = 32'd1; pv[2] = 32'd2;
    run_matrix(2);
    drain();

    rdy_mode = 2;
    for (int m = 0; m < 40; m++) begin
      int n;
      n = $urandom_range(0, 6);
      pv[0] = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFC : $urandom;
      for (int i = 1; i <= n; i++) begin
        if ($urandom_range(0, 9) == 0) pv[i] = pv[i-1] - 32'($urandom_range(1, 5));
        else pv[i] = pv[i-1] + 32'($urandom_range(0, 5));
      end
      run_matrix(n);
    end
    drain();

    rdy_mode = 3;
    drive_ptr(32'd0, 1'b0);
    drive_ptr(32'd4, 1'b0);
    @(posedge clk);
    #1;
    check("stalled_beat_pending", m_tvalid, 1'b1);
    #1;
    rst = 1'b1;
    exp_beats.delete(); exp_rows.delete(); exp_errq.delete();
    mdl_err = 1'b0;
    #1;
    check("async_reset_tvalid", m_tvalid, 1'b0);
    check("async_reset_ptr_tready", s_tready, 1'b0);
    check("async_reset_err", err_nonmono, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    pv[0] = 32'd0; pv[1] = 32'd6;
    run_matrix(1);
    drain();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
